// File: rtl/uart_fifo_pkg.sv
// Shared constants and pointer helpers for the UART transmit ring FIFO.
package uart_fifo_pkg;

    localparam int DROP_CNT_W = 16;

    // Advance a ring pointer, wrapping explicitly so any depth >= 2 works.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port, contents not reset.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_ring_fifo.sv
// Circular-buffer UART transmit FIFO with FWFT read side, flush and sticky overflow.
// Define UART_TX_FIFO_DROP_CNT_EN to build the saturating rejected-write counter.
module uart_tx_ring_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ena,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        tx_data_in,
    input  logic                         tx_data_in_valid,
    output logic                         tx_data_in_ready,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         overflow,
    output logic [DROP_CNT_W-1:0]        drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, wr_en, rd_en, ovf_evt;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // No pass-through when full: a same-cycle read does not free a slot for the write.
    assign tx_data_in_ready = ena & ~full & ~flush;
    assign tx_valid         = ena & ~empty;
    assign wr_en            = tx_data_in_valid & tx_data_in_ready;
    assign rd_en            = tx_valid & tx_ready;
    assign ovf_evt          = ena & tx_data_in_valid & ~tx_data_in_ready & ~flush;

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (tx_data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (tx_data)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (ena) begin
            if (flush) begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), 32'(DEPTH)));
                end
                if (rd_en) begin
                    rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
                end
                case ({wr_en, rd_en})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
                if (ovf_evt) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (ena) begin
            if (flush) begin
                drop_d = '0;
            end else if (ovf_evt && (drop_q != '1)) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

    assign count       = count_q;
    assign almost_full = (count_q >= CNT_W'(ALMOST_FULL_LEVEL));
    assign overflow    = overflow_q;

endmodule
